// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared state type and default width for down_counter_tc
package down_counter_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/down_counter_tc.sv
// down_counter_tc: loadable down-counter with one-cycle terminal-count pulse
// Ports: clk, rst (sync, active-high); entrada load value; load strobe; countDown enable;
//        REz count; zero (REz==0); tc expiry pulse; busy (state RUN).
// Option: DOWN_COUNTER_AUTO_RELOAD_EN reloads the last loaded value on expiry instead of stopping.
module down_counter_tc
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada,
  input  logic             load,
  input  logic             countDown,
  output logic [WIDTH-1:0] REz,
  output logic             zero,
  output logic             tc,
  output logic             busy
);
  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] w_rez_n;
  logic             w_tc_n;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`endif
  // In RUN the count is never 0, so the REz==1 branch is the only expiry path.
  always_comb begin
    w_rez_n   = REz;
    w_state_n = r_state;
    w_tc_n    = 1'b0;
    if (load) begin
      w_rez_n   = entrada;
      w_state_n = (entrada != '0) ? RUN : DONE;
    end else if (r_state == RUN && countDown) begin
      if (REz > WIDTH'(1)) begin
        w_rez_n = REz - WIDTH'(1);
      end else if (REz == WIDTH'(1)) begin
        w_tc_n = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        w_rez_n = r_reload;
`else
        w_rez_n   = '0;
        w_state_n = DONE;
`endif
      end
    end
  end
  // zero/busy derive from next-state values so they line up with REz.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      REz     <= '0;
      tc      <= 1'b0;
      zero    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      REz     <= w_rez_n;
      tc      <= w_tc_n;
      zero    <= (w_rez_n == '0);
      busy    <= (w_state_n == RUN);
    end
  end
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  always_ff @(posedge clk) begin
    if (rst) r_reload <= '0;
    else if (load) r_reload <= entrada;
  end
`endif
endmodule

// File: tb/tb_down_counter_tc.sv
// tb_down_counter_tc: randomized and directed self-checking bench for down_counter_tc
module tb_down_counter_tc;
  import down_counter_pkg::*;
  localparam int W = DEF_WIDTH;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic         countDown = 1'b0;
  logic [W-1:0] entrada = '0;
  logic [W-1:0] REz;
  logic         zero, tc, busy;
  int           n_chk = 0;
  int           n_fail = 0;
  int           m_rez = 0;
  int           m_reload = 0;
  bit           m_run = 0;
  bit           m_tc = 0;

  always #5 clk = ~clk;

  down_counter_tc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .entrada(entrada), .load(load), .countDown(countDown),
    .REz(REz), .zero(zero), .tc(tc), .busy(busy)
  );

  task automatic step(input bit r, input bit ld, input bit cd, input int v);
    rst = r;
    load = ld;
    countDown = cd;
    entrada = W'(v);
    m_tc = 0;
    if (r) begin
      m_rez = 0;
      m_reload = 0;
      m_run = 0;
    end else if (ld) begin
      m_rez = v;
      m_reload = v;
      m_run = (v != 0);
    end else if (m_run && cd) begin
      m_rez = m_rez - 1;
      if (m_rez == 0) begin
        m_tc = 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        m_rez = m_reload;
`else
        m_run = 0;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    n_chk++;
    if (REz !== 0 || zero !== 1 || tc !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL reset_initial: REz=%0d zero=%b tc=%b busy=%b want 0/1/0/0", REz, zero, tc, busy);
    end
    step(0, 1, 0, 6);
    step(0, 0, 1, 0);
    n_chk++;
    if (REz !== 5 || busy !== 1) begin
      n_fail++;
      $display("FAIL reset_setup: REz=%0d busy=%b want 5/1", REz, busy);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1, 0);
      n_chk++;
      if (REz !== 0 || zero !== 1 || tc !== 0 || busy !== 0) begin
        n_fail++;
        $display("FAIL reset_midrun[%0d]: REz=%0d zero=%b tc=%b busy=%b want 0/1/0/0", i, REz, zero, tc, busy);
      end
    end
    step(0, 0, 1, 0);
    n_chk++;
    if (REz !== 0 || busy !== 0 || tc !== 0) begin
      n_fail++;
      $display("FAIL reset_idle_ignores_cd: REz=%0d busy=%b tc=%b want 0/0/0", REz, busy, tc);
    end
  endtask

  task automatic test_one_shot();
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    int exp_r[7] = '{2, 1, 0, 0, 0, 0, 0};
    step(0, 1, 0, 3);
    n_chk++;
    if (REz !== 3 || busy !== 1 || tc !== 0 || zero !== 0) begin
      n_fail++;
      $display("FAIL one_shot_load: REz=%0d busy=%b tc=%b zero=%b want 3/1/0/0", REz, busy, tc, zero);
    end
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 0);
      n_chk++;
      if (REz !== W'(exp_r[i]) || tc !== (i == 2) || busy !== (i < 2) || zero !== (exp_r[i] == 0)) begin
        n_fail++;
        $display("FAIL one_shot[%0d]: REz=%0d tc=%b busy=%b zero=%b want %0d/%b/%b/%b",
                 i, REz, tc, busy, zero, exp_r[i], i == 2, i < 2, exp_r[i] == 0);
      end
    end
`endif
  endtask

  task automatic test_auto_reload();
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    int exp_r[6] = '{1, 2, 1, 2, 1, 2};
    step(0, 1, 0, 2);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0);
      n_chk++;
      if (REz !== W'(exp_r[i]) || tc !== (exp_r[i] == 2) || zero !== 0 || busy !== 1) begin
        n_fail++;
        $display("FAIL auto_reload[%0d]: REz=%0d tc=%b zero=%b busy=%b want %0d/%b/0/1",
                 i, REz, tc, zero, busy, exp_r[i], exp_r[i] == 2);
      end
    end
`endif
  endtask

  task automatic test_priority();
    step(0, 1, 0, 5);
    step(0, 0, 1, 0);
    step(0, 1, 1, 7);
    n_chk++;
    if (REz !== 7 || tc !== 0 || busy !== 1) begin
      n_fail++;
      $display("FAIL priority: REz=%0d tc=%b busy=%b want 7/0/1", REz, tc, busy);
    end
  endtask

  task automatic test_load_zero();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    n_chk++;
    if (REz !== 0 || zero !== 1 || tc !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL load_zero: REz=%0d zero=%b tc=%b busy=%b want 0/1/0/0", REz, zero, tc, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      n_chk++;
      if (REz !== 0 || tc !== 0 || busy !== 0) begin
        n_fail++;
        $display("FAIL load_zero_hold[%0d]: REz=%0d tc=%b busy=%b want 0/0/0", i, REz, tc, busy);
      end
    end
  endtask

  task automatic test_gaps();
    bit pat[4] = '{1, 0, 0, 1};
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    int exp_r[4] = '{1, 1, 1, 2};
`else
    int exp_r[4] = '{1, 1, 1, 0};
`endif
    step(0, 1, 0, 2);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, pat[i], 0);
      n_chk++;
      if (REz !== W'(exp_r[i]) || tc !== (i == 3)) begin
        n_fail++;
        $display("FAIL gaps[%0d]: REz=%0d tc=%b want %0d/%b", i, REz, tc, exp_r[i], i == 3);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 6)));
      n_chk++;
      if (REz !== W'(m_rez) || zero !== (m_rez == 0) || tc !== m_tc || busy !== m_run) begin
        n_fail++;
        $display("FAIL random[%0d]: REz=%0d zero=%b tc=%b busy=%b want %0d/%b/%b/%b",
                 i, REz, zero, tc, busy, m_rez, m_rez == 0, m_tc, m_run);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_priority();
    test_load_zero();
    test_gaps();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
